lc3_pipe_ctrl: RTL and testbench

//  Sequencing controller for the LC-3 pipeline (fetch/decode/execute/writeback/memaccess).

---
 rtl/lc3_pkg.sv | 55 +++++
 rtl/lc3_hazard_detect.sv | 35 +++
 rtl/lc3_pipe_ctrl.sv | 126 ++++++++++++
 tb/tb_lc3_pipe_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 encodings for the pipeline controller: opcodes, memaccess states
// and the instruction field layout used for hazard decoding.
package lc3_pkg;

    typedef enum logic [3:0] {
        OP_BR   = 4'h0,
        OP_ADD  = 4'h1,
        OP_LD   = 4'h2,
        OP_ST   = 4'h3,
        OP_JSR  = 4'h4,
        OP_AND  = 4'h5,
        OP_LDR  = 4'h6,
        OP_STR  = 4'h7,
        OP_RTI  = 4'h8,
        OP_NOT  = 4'h9,
        OP_LDI  = 4'hA,
        OP_STI  = 4'hB,
        OP_JMP  = 4'hC,
        OP_RES  = 4'hD,
        OP_LEA  = 4'hE,
        OP_TRAP = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        MS_READ  = 2'b00,
        MS_IND   = 2'b01,
        MS_WRITE = 2'b10,
        MS_IDLE  = 2'b11
    } mem_state_t;

    // Operate-format field layout; dr doubles as the BR nzp mask.
    typedef struct packed {
        opcode_t    op;
        logic [2:0] dr;
        logic [2:0] sr1;
        logic       imm_sel;
        logic [1:0] mid;
        logic [2:0] sr2;
    } instr_t;

    localparam int unsigned BR_CNT_W = 3;

    function automatic logic uses_sr2(input opcode_t op, input logic imm_sel);
        return ((op == OP_ADD) || (op == OP_AND)) && !imm_sel;
    endfunction

    function automatic logic is_alu(input opcode_t op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
    endfunction

    function automatic logic is_load(input opcode_t op);
        return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
    endfunction

endpackage

// File: rtl/lc3_hazard_detect.sv
// Combinational decode/execute register-dependency check: ALU bypass selects
// and load-use detection, per source operand.
module lc3_hazard_detect
    import lc3_pkg::*;
(
    input  logic [15:0] ir,
    input  logic [15:0] ir_exec,
    output logic        bypass_alu_1,
    output logic        bypass_alu_2,
    output logic        load_use_1,
    output logic        load_use_2,
    output logic        load_use
);

    instr_t dec_i;
    instr_t exe_i;
    logic   hit_1;
    logic   hit_2;
    logic   unused_fields;

    assign dec_i = ir;
    assign exe_i = ir_exec;
    assign unused_fields = ^{dec_i.dr, dec_i.mid, exe_i.sr1, exe_i.imm_sel, exe_i.mid, exe_i.sr2};

    always_comb begin
        hit_1        = (exe_i.dr == dec_i.sr1);
        hit_2        = uses_sr2(dec_i.op, dec_i.imm_sel) && (exe_i.dr == dec_i.sr2);
        bypass_alu_1 = is_alu(exe_i.op) && hit_1;
        bypass_alu_2 = is_alu(exe_i.op) && hit_2;
        load_use_1   = is_load(exe_i.op) && hit_1;
        load_use_2   = is_load(exe_i.op) && hit_2;
        load_use     = load_use_1 || load_use_2;
    end

endmodule

// File: rtl/lc3_pipe_ctrl.sv
// LC-3 pipeline sequencing controller: stage enables, operand bypass selects,
// branch freeze counter and the memaccess FSM. Holds control state only.
module lc3_pipe_ctrl
    import lc3_pkg::*;
#(
    parameter int unsigned BR_PENALTY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        complete_instr,
    input  logic        complete_data,
    input  logic [15:0] imem_dout,
    input  logic [15:0] ir,
    input  logic [15:0] ir_exec,
    input  logic [2:0]  psr,
    output logic        enable_updatepc,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        bypass_alu_1,
    output logic        bypass_alu_2,
    output logic        bypass_mem_1,
    output logic        bypass_mem_2,
    output logic        br_taken,
    output logic [1:0]  mem_state
);

    localparam logic [BR_CNT_W-1:0] BR_LOAD = BR_PENALTY[BR_CNT_W-1:0];

    mem_state_t          state;
    mem_state_t          state_nxt;
    logic                running;
    logic [BR_CNT_W-1:0] br_cnt;
    logic                br_jmp;
    logic                ind_store;
    logic [1:0]          lu_pend;

    opcode_t op_exec;
    opcode_t op_fetch;
    logic    alu_1, alu_2, lu_1, lu_2, lu_any;
    logic    exec_en, pc_ok, br_fire, br_load;
    logic    unused_imem;

    assign op_exec     = opcode_t'(ir_exec[15:12]);
    assign op_fetch    = opcode_t'(imem_dout[15:12]);
    assign unused_imem = ^{imem_dout[11:0], lu_any};
    assign mem_state   = state;

    lc3_hazard_detect u_hazard (
        .ir           (ir),
        .ir_exec      (ir_exec),
        .bypass_alu_1 (alu_1),
        .bypass_alu_2 (alu_2),
        .load_use_1   (lu_1),
        .load_use_2   (lu_2),
        .load_use     (lu_any)
    );

    always_comb begin
        state_nxt        = state;
        exec_en          = running && (state == MS_IDLE);
        pc_ok            = exec_en && complete_instr && (br_cnt == '0);
        br_fire          = exec_en && (br_cnt == BR_CNT_W'(1)) && (br_jmp || (|(ir_exec[11:9] & psr)));
        br_load          = pc_ok && ((op_fetch == OP_BR) || (op_fetch == OP_JMP));

        enable_execute   = exec_en;
        enable_decode    = exec_en && complete_instr;
        enable_fetch     = pc_ok;
        enable_updatepc  = pc_ok || br_fire;
        enable_writeback = running && ((state == MS_IDLE) || ((state == MS_READ) && complete_data));
        br_taken         = br_fire;
        // Memory-forwarded operand takes priority over the ALU forward.
        bypass_mem_1     = exec_en && lu_pend[0];
        bypass_mem_2     = exec_en && lu_pend[1];
        bypass_alu_1     = running && alu_1 && !bypass_mem_1;
        bypass_alu_2     = running && alu_2 && !bypass_mem_2;

        case (state)
            MS_IDLE: begin
                if (exec_en) begin
                    case (op_exec)
                        OP_LD, OP_LDR:  state_nxt = MS_READ;
                        OP_LDI, OP_STI: state_nxt = MS_IND;
                        OP_ST, OP_STR:  state_nxt = MS_WRITE;
                        default:        state_nxt = MS_IDLE;
                    endcase
                end
            end
            MS_IND: begin
                if (complete_data) state_nxt = ind_store ? MS_WRITE : MS_READ;
            end
            MS_READ, MS_WRITE: begin
                if (complete_data) state_nxt = MS_IDLE;
            end
            default: state_nxt = MS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running   <= 1'b0;
            state     <= MS_IDLE;
            br_cnt    <= '0;
            br_jmp    <= 1'b0;
            ind_store <= 1'b0;
            lu_pend   <= '0;
        end else begin
            running <= 1'b1;
            state   <= state_nxt;
            // ir_exec moves on as the access launches, so remember what the
            // indirect access and any dependent operand need later.
            if (exec_en) begin
                ind_store <= (op_exec == OP_STI);
                lu_pend   <= {lu_2, lu_1};
            end
            if (br_load) begin
                br_cnt <= BR_LOAD;
                br_jmp <= (op_fetch == OP_JMP);
            end else if (exec_en && (br_cnt != '0)) begin
                br_cnt <= br_cnt - BR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_lc3_pipe_ctrl.sv
// Scoreboard bench for lc3_pipe_ctrl: a toy pipeline feeds directed and random
// instruction streams; an access-phase-list reference model predicts every cycle.
module tb_lc3_pipe_ctrl;

    localparam int unsigned BRP = 3;
    localparam logic [1:0] S_READ = 2'b00, S_IND = 2'b01, S_WRITE = 2'b10, S_IDLE = 2'b11;
    localparam logic [3:0] O_BR = 4'h0, O_ADD = 4'h1, O_LD = 4'h2, O_ST = 4'h3, O_AND = 4'h5,
                           O_LDR = 4'h6, O_STR = 4'h7, O_NOT = 4'h9, O_LDI = 4'hA,
                           O_STI = 4'hB, O_JMP = 4'hC, O_LEA = 4'hE;
    localparam logic [15:0] BUBBLE = 16'hE000;

    logic        clk = 1'b0;
    logic        rst;
    logic        complete_instr, complete_data;
    logic [15:0] imem_dout, ir, ir_exec;
    logic [2:0]  psr;
    logic        enable_updatepc, enable_fetch, enable_decode, enable_execute, enable_writeback;
    logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, br_taken;
    logic [1:0]  mem_state;

    always #5 clk = ~clk;

    lc3_pipe_ctrl #(.BR_PENALTY(BRP)) dut (
        .clk              (clk),
        .rst              (rst),
        .complete_instr   (complete_instr),
        .complete_data    (complete_data),
        .imem_dout        (imem_dout),
        .ir               (ir),
        .ir_exec          (ir_exec),
        .psr              (psr),
        .enable_updatepc  (enable_updatepc),
        .enable_fetch     (enable_fetch),
        .enable_decode    (enable_decode),
        .enable_execute   (enable_execute),
        .enable_writeback (enable_writeback),
        .bypass_alu_1     (bypass_alu_1),
        .bypass_alu_2     (bypass_alu_2),
        .bypass_mem_1     (bypass_mem_1),
        .bypass_mem_2     (bypass_mem_2),
        .br_taken         (br_taken),
        .mem_state        (mem_state)
    );

    typedef struct packed {
        logic upc, fet, dec, exe, wb, ba1, ba2, bm1, bm2, bt;
        logic [1:0] ms;
    } obs_t;

    typedef struct {
        obs_t o;
        int   cyc;
    } sb_t;

    sb_t  sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Reference model: the pending memory access is a list of remaining phases.
    bit         started;
    int         br_left;
    bit         br_jmp;
    logic [1:0] acc[$];
    bit         pend1, pend2;
    int         age;
    obs_t       cur_exp;
    logic [15:0] prog[$];
    bit         rnd_mode = 1'b0;

    function automatic bit reads_sr2(input logic [15:0] i);
        return ((i[15:12] == O_ADD) || (i[15:12] == O_AND)) && !i[5];
    endfunction

    function automatic logic [15:0] rnd_instr();
        logic [15:0] w;
        logic [3:0]  op;
        case ($urandom_range(0, 11))
            0: op = O_ADD;   1: op = O_AND;   2: op = O_NOT;  3: op = O_LD;
            4: op = O_LDR;   5: op = O_LDI;   6: op = O_ST;   7: op = O_STR;
            8: op = O_STI;   9: op = O_BR;   10: op = O_JMP;  default: op = O_LEA;
        endcase
        w = 16'($urandom);
        w[15:12] = op;
        w[11:9]  = 3'($urandom_range(0, 3));
        w[8:6]   = 3'($urandom_range(0, 3));
        w[2:0]   = 3'($urandom_range(0, 3));
        return w;
    endfunction

    function automatic logic [15:0] next_instr();
        if (prog.size() != 0) return prog.pop_front();
        if (rnd_mode) return rnd_instr();
        return BUBBLE;
    endfunction

    function automatic obs_t expect_now();
        obs_t o;
        bit   busy, go, take, pc_ok, alu;
        o = '0;
        if (rst) begin
            o.ms = S_IDLE;
            return o;
        end
        busy  = (acc.size() != 0);
        o.ms  = busy ? acc[0] : S_IDLE;
        go    = started && !busy;
        take  = go && (br_left == 1) && (br_jmp || ((ir_exec[11:9] & psr) != 3'b000));
        pc_ok = go && complete_instr && (br_left == 0);
        o.upc = pc_ok || take;
        o.fet = pc_ok;
        o.dec = go && complete_instr;
        o.exe = go;
        o.wb  = started && (busy ? ((acc[0] == S_READ) && complete_data) : 1'b1);
        o.bm1 = go && pend1;
        o.bm2 = go && pend2;
        alu   = ir_exec[15:12] inside {O_ADD, O_AND, O_NOT};
        o.ba1 = started && alu && (ir_exec[11:9] == ir[8:6]) && !o.bm1;
        o.ba2 = started && alu && reads_sr2(ir) && (ir_exec[11:9] == ir[2:0]) && !o.bm2;
        o.bt  = take;
        return o;
    endfunction

    task automatic reset_model();
        started = 1'b0;
        br_left = 0;
        br_jmp  = 1'b0;
        acc.delete();
        pend1   = 1'b0;
        pend2   = 1'b0;
        age     = 0;
    endtask

    // Advance the model and the toy pipeline across one clock edge.
    task automatic model_edge();
        obs_t       e;
        logic [3:0] eop;
        bit         ld;
        e   = cur_exp;
        eop = ir_exec[15:12];
        if (rst) begin
            reset_model();
            return;
        end
        if (!started) begin
            started = 1'b1;
            return;
        end
        age++;
        if (e.exe) begin
            ld    = eop inside {O_LD, O_LDR, O_LDI};
            pend1 = ld && (ir_exec[11:9] == ir[8:6]);
            pend2 = ld && reads_sr2(ir) && (ir_exec[11:9] == ir[2:0]);
            case (eop)
                O_LD, O_LDR: acc.push_back(S_READ);
                O_LDI:       begin acc.push_back(S_IND); acc.push_back(S_READ);  end
                O_STI:       begin acc.push_back(S_IND); acc.push_back(S_WRITE); end
                O_ST, O_STR: acc.push_back(S_WRITE);
                default: ;
            endcase
            if (acc.size() != 0) age = 0;
        end else if ((acc.size() != 0) && complete_data) begin
            void'(acc.pop_front());
            age = 0;
        end
        if (e.fet && (imem_dout[15:12] inside {O_BR, O_JMP})) begin
            br_left = BRP;
            br_jmp  = (imem_dout[15:12] == O_JMP);
        end else if (e.exe && (br_left > 0)) begin
            br_left--;
        end
        if (e.exe) begin
            ir_exec = ir;
            ir      = e.dec ? imem_dout : BUBBLE;
        end
        if (e.fet) imem_dout = next_instr();
    endtask

    task automatic step(input bit r);
        sb_t item;
        @(posedge clk);
        #1;
        model_edge();
        cyc++;
        rst = r;
        if (r) reset_model();
        complete_instr = rnd_mode ? ($urandom_range(0, 99) < 85) : 1'b1;
        complete_data  = rnd_mode ? ($urandom_range(0, 99) < 40) : ((acc.size() != 0) && (age == 1));
        if (rnd_mode && ($urandom_range(0, 7) == 0)) psr = 3'b001 << $urandom_range(0, 2);
        cur_exp = expect_now();
        item.o   = cur_exp;
        item.cyc = cyc;
        sb.push_back(item);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    always @(negedge clk) begin
        sb_t  e;
        obs_t got;
        if (sb.size() != 0) begin
            e   = sb.pop_front();
            got = {enable_updatepc, enable_fetch, enable_decode, enable_execute, enable_writeback,
                   bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, br_taken, mem_state};
            checks++;
            if (got !== e.o) begin
                failures++;
                $display("FAIL outs cyc=%0d got=%b exp=%b (upc fet dec exe wb ba1 ba2 bm1 bm2 bt ms[1:0])",
                         e.cyc, got, e.o);
            end
        end
    end

    initial begin
        rst            = 1'b1;
        complete_instr = 1'b1;
        complete_data  = 1'b0;
        imem_dout      = BUBBLE;
        ir             = BUBBLE;
        ir_exec        = BUBBLE;
        psr            = 3'b010;
        reset_model();
        cur_exp = '0;

        repeat (3) step(1'b1);
        run(4);
        // ADD R1,R2,R3 ; ADD R4,R1,R1
        prog.push_back(16'h1283); prog.push_back(16'h1841);
        run(8);
        // LDI R2 ; STI R3 with two-cycle memory phases
        prog.push_back(16'hA405); prog.push_back(16'hB605);
        run(24);
        // LD R5 ; AND R6,R5,#1
        prog.push_back(16'h2A01); prog.push_back(16'h5D61);
        run(12);
        // BRz followed by instructions whose [11:9] is 010
        psr = 3'b010;
        prog.push_back(16'h0403); prog.push_back(16'h94BF); prog.push_back(16'h94BF);
        run(10);
        psr = 3'b100;
        prog.push_back(16'h0403); prog.push_back(16'h94BF); prog.push_back(16'h94BF);
        run(10);
        // LD R1 ; NOT R2,R3 ; JMP R7 -- JMP arrives as the LD launches
        psr = 3'b010;
        prog.push_back(16'h2201); prog.push_back(16'h94FF); prog.push_back(16'hC1C0);
        run(16);
        // reset in the middle of an indirect access
        prog.push_back(16'hA405);
        for (int i = 0; (i < 20) && !((acc.size() != 0) && (acc[0] == S_IND)); i++) step(1'b0);
        step(1'b1);
        step(1'b1);
        run(6);

        rnd_mode = 1'b1;
        for (int i = 0; i < 2000; i++) step($urandom_range(0, 299) == 0);

        repeat (2) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
